// File: rtl/fsm_multi_pkg.sv
// Shared types and helpers for the fsm_multi controller.
// The arbitration mode is selected by the FSM_MULTI_RR_EN macro.
package fsm_multi_pkg;

  // Supported range for the number of request channels
  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 16;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Bits needed to hold values 0..v-1, never less than one
  function automatic int unsigned width_of(input int unsigned v);
    if (v < 2) begin
      return 1;
    end
    return $clog2(v);
  endfunction

endpackage

// File: rtl/fsm_multi_arb.sv
// Combinational channel picker for fsm_multi.
// FSM_MULTI_RR_EN defined: round-robin search starting after ptr_i.
// FSM_MULTI_RR_EN undefined: fixed priority, lowest asserted index wins.
module fsm_multi_arb
  import fsm_multi_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = width_of(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_c,
  output logic          valid_c
);

  assign valid_c = |req_i;

`ifdef FSM_MULTI_RR_EN
  int unsigned cand;
  logic        found;

  // Walk the channels from ptr+1 around to ptr, take the first request
  always_comb begin
    idx_c = '0;
    cand  = 0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(ptr_i) + i) % N;
      if (!found && req_i[IW'(cand)]) begin
        found = 1'b1;
        idx_c = IW'(cand);
      end
    end
  end
`else
  logic unused_ptr;

  // Pointer has no meaning in fixed-priority mode
  assign unused_ptr = ^ptr_i;

  // Scan from the top down so the lowest asserted index is kept last
  always_comb begin
    idx_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[IW'(i)]) begin
        idx_c = IW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/fsm_multi.sv
// N-channel dwell/guard controller: grants one requesting channel at a
// time, holds it for DWELL cycles, pulses T on clean completion, then
// rests GAP cycles plus one IDLE cycle before the next grant.
// FSM_MULTI_RR_EN selects round-robin arbitration (default: fixed priority).
module fsm_multi
  import fsm_multi_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned DWELL = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N-1:0]           M,
  output logic [N-1:0]           C,
  output logic                   T,
  output logic                   BUSY,
  output logic [width_of(N)-1:0] CH
);

  localparam int unsigned IW      = width_of(N);
  localparam int unsigned CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CW      = width_of(CNT_MAX + 1);

  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP > 0) ? CW'(GAP - 1) : '0;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  c_q,     c_d;
  logic          t_q,     t_d;
  logic          busy_q,  busy_d;
  logic [IW-1:0] ch_q,    ch_d;

  logic [IW-1:0] arb_idx_c;
  logic          arb_valid_c;
  logic [IW-1:0] arb_ptr_c;
  logic          grant_c;
  logic          enter_rest_c;

  fsm_multi_arb #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .req_i   (M),
    .ptr_i   (arb_ptr_c),
    .idx_c   (arb_idx_c),
    .valid_c (arb_valid_c)
  );

  assign grant_c = (state_q == ST_IDLE) && arb_valid_c;

`ifdef FSM_MULTI_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Pointer follows every grant, aborted ones included
  assign ptr_d     = grant_c ? arb_idx_c : ptr_q;
  assign arb_ptr_c = ptr_q;

  // Round-robin pointer register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign arb_ptr_c = '0;
`endif

  // Next state, counter and output values
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    c_d          = c_q;
    t_d          = 1'b0;
    ch_d         = ch_q;
    enter_rest_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          state_d = ST_SERVE;
          cnt_d   = DWELL_LOAD;
          c_d     = N'(1) << arb_idx_c;
          ch_d    = arb_idx_c;
        end
      end
      ST_SERVE: begin
        if (!M[ch_q]) begin
          // Granted channel withdrew: drop it without a completion pulse
          c_d          = '0;
          enter_rest_c = 1'b1;
        end else if (cnt_q == '0) begin
          c_d          = '0;
          t_d          = 1'b1;
          enter_rest_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        c_d     = '0;
      end
    endcase

    // Leaving SERVE: guard gap if configured, otherwise straight to IDLE
    if (enter_rest_c) begin
      if (GAP > 0) begin
        state_d = ST_GAP;
        cnt_d   = GAP_LOAD;
      end else begin
        state_d = ST_IDLE;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      c_q     <= '0;
      t_q     <= 1'b0;
      busy_q  <= 1'b0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
      ch_q    <= ch_d;
    end
  end

  assign C    = c_q;
  assign T    = t_q;
  assign BUSY = busy_q;
  assign CH   = ch_q;

endmodule

// File: tb/tb_fsm_multi.sv
// Self-checking bench for fsm_multi: directed tables plus randomized
// requests against a timeline-based reference model.
`timescale 1ns/1ps
module tb_fsm_multi;

  localparam int unsigned N1 = 2;
  localparam int unsigned D1 = 4;
  localparam int unsigned G1 = 1;
  localparam int unsigned N2 = 4;
  localparam int unsigned D2 = 1;
  localparam int unsigned G2 = 0;

`ifdef FSM_MULTI_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [3:0] m;
    logic [3:0] c;
    logic       t;
    logic       busy;
    logic [1:0] ch;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] M1;
  logic [1:0] C1;
  logic       T1, B1;
  logic       CH1;
  logic [3:0] M2;
  logic [3:0] C2;
  logic       T2, B2;
  logic [1:0] CH2;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  fsm_multi #(.N(N1), .DWELL(D1), .GAP(G1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .M(M1), .C(C1), .T(T1), .BUSY(B1), .CH(CH1)
  );

  fsm_multi #(.N(N2), .DWELL(D2), .GAP(G2)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .M(M2), .C(C2), .T(T2), .BUSY(B2), .CH(CH2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t vv(input logic [3:0] m, input logic [3:0] c,
                              input logic t, input logic b, input logic [1:0] ch);
    vec_t r;
    r.m = m; r.c = c; r.t = t; r.busy = b; r.ch = ch;
    return r;
  endfunction

  // Reference model: each serve is a time window [grant edge, end edge)
  // and the next grant is legal from end edge + GAP + 1 onward.
  int n_edge;
  int g_e[2], k_ch[2], end_e[2], free_e[2], last[2];
  bit active[2], fin[2], abrt[2];

  function automatic bit bit_of(input logic [15:0] m, input int i);
    return ((m >> i) & 16'd1) != 16'd0;
  endfunction

  function automatic int pick(input int id, input logic [15:0] m, input int nn);
    if (RR) begin
      for (int i = 1; i <= nn; i++)
        if (bit_of(m, (last[id] + i) % nn)) return (last[id] + i) % nn;
    end else begin
      for (int i = 0; i < nn; i++)
        if (bit_of(m, i)) return i;
    end
    return 0;
  endfunction

  task automatic model_reset(input int id);
    active[id] = 1'b0; fin[id] = 1'b0; abrt[id] = 1'b0;
    last[id] = 0; free_e[id] = 0; end_e[id] = -100; g_e[id] = -100; k_ch[id] = 0;
  endtask

  task automatic model_step(input int id, input logic [15:0] m, input int nn,
                            input int dwell, input int gap);
    if (active[id] && !fin[id]) begin
      if (!bit_of(m, k_ch[id])) begin
        fin[id] = 1'b1; abrt[id] = 1'b1; end_e[id] = n_edge; free_e[id] = n_edge + gap + 1;
      end else if (n_edge == g_e[id] + dwell) begin
        fin[id] = 1'b1; abrt[id] = 1'b0; end_e[id] = n_edge; free_e[id] = n_edge + gap + 1;
      end
    end else if (n_edge >= free_e[id] && m != 16'd0) begin
      g_e[id] = n_edge; k_ch[id] = pick(id, m, nn); last[id] = k_ch[id];
      active[id] = 1'b1; fin[id] = 1'b0; abrt[id] = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_exp(input int id, input int gap, input int chw);
    int c, t, b;
    c = (active[id] && !fin[id]) ? (1 << k_ch[id]) : 0;
    t = (active[id] && fin[id] && !abrt[id] && n_edge == end_e[id]) ? 1 : 0;
    b = ((active[id] && !fin[id]) ||
         (active[id] && fin[id] && n_edge < end_e[id] + gap)) ? 1 : 0;
    return 32'((c << (chw + 2)) | (t << (chw + 1)) | (b << chw) | last[id]);
  endfunction

  vec_t tbl1[26];
  vec_t tbl2[6];
  int   rst_left;

  initial begin
    // M=01 held, then M=11 held, then M=10 aborts and a dropped request
    for (int i = 0; i < 4; i++) tbl1[i] = vv(4'd1, 4'd1, 1'b0, 1'b1, 2'd0);
    tbl1[4]  = vv(4'd1, 4'd0, 1'b1, 1'b1, 2'd0);
    tbl1[5]  = vv(4'd1, 4'd0, 1'b0, 1'b0, 2'd0);
    tbl1[6]  = vv(4'd1, 4'd1, 1'b0, 1'b1, 2'd0);
    for (int i = 7; i < 10; i++) tbl1[i] = vv(4'd3, 4'd1, 1'b0, 1'b1, 2'd0);
    tbl1[10] = vv(4'd3, 4'd0, 1'b1, 1'b1, 2'd0);
    tbl1[11] = vv(4'd3, 4'd0, 1'b0, 1'b0, 2'd0);
    for (int i = 12; i < 16; i++)
      tbl1[i] = vv(4'd3, RR ? 4'd2 : 4'd1, 1'b0, 1'b1, RR ? 2'd1 : 2'd0);
    tbl1[16] = vv(4'd3, 4'd0, 1'b1, 1'b1, RR ? 2'd1 : 2'd0);
    tbl1[17] = vv(4'd3, 4'd0, 1'b0, 1'b0, RR ? 2'd1 : 2'd0);
    tbl1[18] = vv(4'd3, 4'd1, 1'b0, 1'b1, 2'd0);
    tbl1[19] = vv(4'd2, 4'd0, 1'b0, 1'b1, 2'd0);
    tbl1[20] = vv(4'd2, 4'd0, 1'b0, 1'b0, 2'd0);
    tbl1[21] = vv(4'd2, 4'd2, 1'b0, 1'b1, 2'd1);
    tbl1[22] = vv(4'd2, 4'd2, 1'b0, 1'b1, 2'd1);
    tbl1[23] = vv(4'd0, 4'd0, 1'b0, 1'b1, 2'd1);
    tbl1[24] = vv(4'd0, 4'd0, 1'b0, 1'b0, 2'd1);
    tbl1[25] = vv(4'd0, 4'd0, 1'b0, 1'b0, 2'd1);

    // N=4, DWELL=1, GAP=0, M=1010 held
    tbl2[0] = vv(4'hA, 4'b0010, 1'b0, 1'b1, 2'd1);
    tbl2[1] = vv(4'hA, 4'b0000, 1'b1, 1'b0, 2'd1);
    tbl2[2] = vv(4'hA, RR ? 4'b1000 : 4'b0010, 1'b0, 1'b1, RR ? 2'd3 : 2'd1);
    tbl2[3] = vv(4'hA, 4'b0000, 1'b1, 1'b0, RR ? 2'd3 : 2'd1);
    tbl2[4] = vv(4'hA, 4'b0010, 1'b0, 1'b1, 2'd1);
    tbl2[5] = vv(4'hA, 4'b0000, 1'b1, 1'b0, 2'd1);

    // Asynchronous reset before any clock edge
    RESET = 1'b0; M1 = '0; M2 = '0;
    #1 RESET = 1'b1;
    #1;
    check("rst0_dut1", 32'({C1, T1, B1, CH1}), 32'd0);
    check("rst0_dut2", 32'({C2, T2, B2, CH2}), 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b0;

    for (int i = 0; i < 26; i++) begin
      M1 = tbl1[i].m[1:0];
      @(posedge CLK); #1;
      check($sformatf("tbl1[%0d]", i), 32'({C1, T1, B1, CH1}),
            32'({tbl1[i].c[1:0], tbl1[i].t, tbl1[i].busy, tbl1[i].ch[0]}));
    end

    // Reset during the third SERVE cycle, then a full-length serve
    M1 = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check($sformatf("pre_rst_serve%0d", i), 32'({C1, T1, B1, CH1}), 32'b10011);
    end
    #3 RESET = 1'b1;
    #1;
    check("mid_rst_async", 32'({C1, T1, B1, CH1}), 32'd0);
    @(posedge CLK); #1;
    check("mid_rst_held", 32'({C1, T1, B1, CH1}), 32'd0);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check($sformatf("post_rst_serve%0d", i), 32'({C1, T1, B1, CH1}), 32'b10011);
    end
    @(posedge CLK); #1;
    check("post_rst_done", 32'({C1, T1, B1, CH1}), 32'b00111);
    M1 = 2'b00;
    @(posedge CLK); #1;
    check("post_rst_gap", 32'({C1, T1, B1, CH1}), 32'b00001);
    @(posedge CLK); #1;
    check("post_rst_idle", 32'({C1, T1, B1, CH1}), 32'b00001);

    for (int i = 0; i < 6; i++) begin
      M2 = tbl2[i].m;
      @(posedge CLK); #1;
      check($sformatf("tbl2[%0d]", i), 32'({C2, T2, B2, CH2}),
            32'({tbl2[i].c, tbl2[i].t, tbl2[i].busy, tbl2[i].ch}));
    end

    // Randomized requests and occasional resets against the model
    M1 = '0; M2 = '0;
    RESET = 1'b1; rst_left = 2; n_edge = 0;
    model_reset(0); model_reset(1);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge CLK); #1;
      n_edge++;
      if (rst_left == 0) begin
        model_step(0, 16'(M1), int'(N1), int'(D1), int'(G1));
        model_step(1, 16'(M2), int'(N2), int'(D2), int'(G2));
      end
      check($sformatf("rnd1 cyc %0d", cyc), 32'({C1, T1, B1, CH1}), model_exp(0, int'(G1), 1));
      check($sformatf("rnd2 cyc %0d", cyc), 32'({C2, T2, B2, CH2}), model_exp(1, int'(G2), 2));
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) RESET = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        RESET = 1'b1; rst_left = 2;
        model_reset(0); model_reset(1);
        #1;
        check($sformatf("rnd_rst1 cyc %0d", cyc), 32'({C1, T1, B1, CH1}), 32'd0);
        check($sformatf("rnd_rst2 cyc %0d", cyc), 32'({C2, T2, B2, CH2}), 32'd0);
      end
      if ($urandom_range(0, 7) == 0) M1 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) M2 = 4'($urandom_range(0, 15));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_multi.md
# fsm_multi

Parametrised successor to the two-input controller FSM: N request inputs, one-hot channel outputs, and a completion pulse. Each granted channel is served for a programmable dwell time, followed by an optional guard gap. Channel selection is round-robin or fixed-priority, chosen at compile time. The block sits where the two-input FSM sits today and drives the same downstream C/T consumers, widened to N.

## Interface
- N, default 2: number of request channels, 2..16.
- DWELL, default 4: SERVE cycles per grant, ≥1.
- GAP, default 1: guard cycles after each serve, ≥0.
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- M  input  N  request levels, one per channel, sampled on CLK.
- C  output  N  one-hot active-channel indication, registered; all zero when no channel is served.
- T  output  1  registered single-cycle pulse on successful (non-aborted) serve completion.
- BUSY  output  1  high in SERVE and GAP.
- CH  output  $clog2(N)  index of the current or most recently served channel.

## Operation
- States: IDLE, SERVE, GAP.
- IDLE:
  - No request (M == 0): stay in IDLE.
  - Any M bit high: the arbiter picks channel k; at the next edge go to SERVE with C = 1<<k, CH = k, and counter = DWELL-1.
- SERVE:
  - Requests on other channels are ignored.
  - Abort: M[k] sampled low → next edge C = 0, T stays 0, go to GAP (or IDLE if GAP = 0).
  - Completion: counter == 0 with M[k] high → next edge C = 0, T = 1 for one cycle, go to GAP with counter = GAP-1 (or IDLE if GAP = 0).
  - Otherwise the counter decrements.
- GAP: C = 0, BUSY = 1; the counter decrements; at 0 go to IDLE.
- An IDLE cycle always separates consecutive serves, including when GAP = 0.
- Counter width is $clog2(max(DWELL,GAP)+1). There is no wrap: the counter only reloads on state entry.
- Reset values (asserted asynchronously, no clock needed): state IDLE, C = 0, T = 0, BUSY = 0, CH = 0, round-robin pointer = 0, counter = 0.
- RESET mid-SERVE or mid-GAP: all outputs drop immediately and any pending T is lost. After release, the next serve is full-length.

## Timing
- Request sampled high at IDLE edge e0 → C valid from e0 until e0+DWELL, i.e. DWELL cycles.
- T is high from e0+DWELL to e0+DWELL+1.
- BUSY rises with C and falls after the last GAP cycle.
- Earliest next grant edge after completion: e0+DWELL+GAP+1.
- Minimum grant-to-grant period: DWELL+GAP+1 cycles.
- Abort latency: M[k] low at edge e → C = 0 after e.
- All outputs are registered; there are no combinational paths from M or RESET release to the outputs.

## Configuration
- FSM_MULTI_RR_EN defined:
  - Round-robin arbitration. The search starts at (CH+1) mod N and wraps.
  - The pointer updates to k on every grant, including grants that are later aborted.
- FSM_MULTI_RR_EN undefined:
  - Fixed priority: the lowest asserted index wins.
  - No pointer register; CH is used only as an output.

## Structure
- Package fsm_multi_pkg holds:
  - the state enum (IDLE, SERVE, GAP);
  - the width helper function for the counter and CH;
  - localparam limits for N.
- One sub-module, fsm_multi_arb: combinational pick of the next index from M and the pointer. It has both arbitration modes under the same macro.
- Top level holds the state register, counter, and output registers.

## Test plan
- Reset at time 0, no clock edge: RESET=1 → C=00, T=0, BUSY=0, CH=0 immediately.
- N=2, DWELL=4, GAP=1, M=01 held → C=01 for 4 cycles, then T=1 for 1 cycle, then GAP, then IDLE, then C=01 again. Period is 6 cycles.
- M=11 held:
  - with FSM_MULTI_RR_EN, C alternates 01, 10, 01, and CH alternates 0, 1, 0;
  - without it, C is always 01.
- Abort: M=10; drop M[1] after the 2nd SERVE cycle → C=00 on the next edge, T never pulses, BUSY covers the 1 GAP cycle.
- Reset mid-serve: RESET=1 during the 3rd SERVE cycle → C=00 and BUSY=0 without a clock edge. After release with M=10, a full 4-cycle serve follows, then T.
- N=4, DWELL=1, GAP=0, M=1010, round-robin → C=0010, 0000, 1000, 0000, 0010, with T pulsing in each 0000 cycle.
